// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI controller arbiter.
// FSM state codes, requester/owner encoding and one-hot helpers.
package qspi_arb_pkg;

    localparam int LINE_LENGTH_DEF = 4;

    // Nibble beats in one line transfer for a given line length in bytes
    function automatic int beats_of(input int line_length);
        beats_of = 2 * line_length;
    endfunction

    localparam int BEATS = beats_of(LINE_LENGTH_DEF);

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Transaction owner
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_W    = 2'd3
    } owner_e;

    // One-hot winner {w,d,i} to owner code
    function automatic owner_e owner_of(input logic [2:0] win_oh);
        case (win_oh)
            3'b001:  owner_of = OWN_I;
            3'b010:  owner_of = OWN_D;
            3'b100:  owner_of = OWN_W;
            default: owner_of = OWN_NONE;
        endcase
    endfunction

    // Owner code to one-hot {w,d,i}
    function automatic logic [2:0] owner_onehot(input owner_e owner);
        case (owner)
            OWN_I:   owner_onehot = 3'b001;
            OWN_D:   owner_onehot = 3'b010;
            OWN_W:   owner_onehot = 3'b100;
            default: owner_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/qspi_arb_prio.sv
// Combinational requester pick for the QSPI arbiter.
// Fixed priority w > d > i. With QSPI_ARB_AGE_EN defined, an I-fill that
// has waited through AGE_LIMIT consecutive data grants wins outright.
module qspi_arb_prio
    import qspi_arb_pkg::*;
#(
    parameter int AGE_LIMIT = 3
) (
`ifdef QSPI_ARB_AGE_EN
    input  logic [1:0] age,
`endif
    input  logic       i_req,
    input  logic       d_req,
    input  logic       w_req,
    output logic [2:0] win_oh
);

    // Pick one winner, one-hot as {w,d,i}; all-zero when nobody requests
    always_comb begin
        win_oh = 3'b000;
`ifdef QSPI_ARB_AGE_EN
        if (i_req && (int'(age) >= AGE_LIMIT)) begin
            win_oh = 3'b001;
        end else if (w_req) begin
`else
        if (w_req) begin
`endif
            win_oh = 3'b100;
        end else if (d_req) begin
            win_oh = 3'b010;
        end else if (i_req) begin
            win_oh = 3'b001;
        end else begin
            win_oh = 3'b000;
        end
    end

endmodule

// File: rtl/qspi_arbiter.sv
// Arbiter sharing one QSPI memory controller between I-fill, D-fill and
// D-writeback. Holds the controller request stable for a whole line, counts
// nibble strobes to find its end, and returns gnt/beat/done to the owner.
// Optional feature macro: QSPI_ARB_AGE_EN (I-fill starvation ageing).
module qspi_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 24
`ifdef QSPI_ARB_AGE_EN
    ,
    parameter int AGE_LIMIT   = 3
`endif
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_req,
    input  logic [1:0]                             i_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]        i_addr,
    output logic                                   i_gnt,
    output logic                                   i_done,
    input  logic                                   d_req,
    input  logic [1:0]                             d_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]        d_addr,
    output logic                                   d_gnt,
    output logic                                   d_done,
    input  logic                                   w_req,
    input  logic [1:0]                             w_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]        w_addr,
    output logic                                   w_gnt,
    output logic                                   w_done,
    output logic                                   q_req,
    output logic                                   q_i_d,
    output logic [1:0]                             q_mem,
    output logic                                   q_write,
    output logic [PA-1:$clog2(LINE_LENGTH)]        q_paddr,
    input  logic                                   q_wstrobe_i,
    input  logic                                   q_wstrobe_d,
    input  logic                                   q_rstrobe_d,
    output logic [$clog2(2*LINE_LENGTH)-1:0]       beat,
    output logic                                   busy
);

    localparam int LW     = $clog2(LINE_LENGTH);
    localparam int NBEATS = beats_of(LINE_LENGTH);
    localparam int BW     = $clog2(NBEATS);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NBEATS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    logic [1:0]       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             busy_q, busy_d;
    logic             q_req_q, q_req_d;
    logic             q_i_d_q, q_i_d_d;
    logic [1:0]       q_mem_q, q_mem_d;
    logic             q_write_q, q_write_d;
    logic [PA-1:LW]   q_paddr_q, q_paddr_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       done_q, done_d;
    logic [2:0]       win_oh_s;
    logic             strobe_s;
`ifdef QSPI_ARB_AGE_EN
    logic [1:0]       age_q, age_d;
`endif

    qspi_arb_prio
`ifdef QSPI_ARB_AGE_EN
        #(.AGE_LIMIT(AGE_LIMIT))
`endif
    u_prio (
`ifdef QSPI_ARB_AGE_EN
        .age    (age_q),
`endif
        .i_req  (i_req),
        .d_req  (d_req),
        .w_req  (w_req),
        .win_oh (win_oh_s)
    );

    // Only the strobe that matches the owner's transfer type counts a beat
    always_comb begin
        case (owner_q)
            OWN_I:   strobe_s = q_wstrobe_i;
            OWN_D:   strobe_s = q_wstrobe_d;
            OWN_W:   strobe_s = q_rstrobe_d;
            default: strobe_s = 1'b0;
        endcase
    end

    // Next-state logic for the FSM, beat counter and controller-side outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        busy_d    = busy_q;
        q_req_d   = q_req_q;
        q_i_d_d   = q_i_d_q;
        q_mem_d   = q_mem_q;
        q_write_d = q_write_q;
        q_paddr_d = q_paddr_q;
        gnt_d     = 3'b000;
        done_d    = 3'b000;
`ifdef QSPI_ARB_AGE_EN
        age_d     = age_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_oh_s != 3'b000) begin
                    state_d   = ST_RUN;
                    owner_d   = owner_of(win_oh_s);
                    gnt_d     = win_oh_s;
                    busy_d    = 1'b1;
                    q_req_d   = 1'b1;
                    beat_d    = '0;
                    q_write_d = win_oh_s[2];
                    q_i_d_d   = win_oh_s[0];
                    case (win_oh_s)
                        3'b100: begin
                            q_mem_d   = w_mem;
                            q_paddr_d = w_addr;
                        end
                        3'b010: begin
                            q_mem_d   = d_mem;
                            q_paddr_d = d_addr;
                        end
                        default: begin
                            q_mem_d   = i_mem;
                            q_paddr_d = i_addr;
                        end
                    endcase
`ifdef QSPI_ARB_AGE_EN
                    // Count data grants that made a pending I-fill wait
                    if (win_oh_s[0]) begin
                        age_d = 2'd0;
                    end else if (i_req) begin
                        age_d = (age_q == 2'd3) ? 2'd3 : age_q + 2'd1;
                    end else begin
                        age_d = 2'd0;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (strobe_s) begin
                    beat_d = beat_q + BEAT_ONE;
                    if (beat_q == BEAT_LAST) begin
                        q_req_d = 1'b0;
                        done_d  = owner_onehot(owner_q);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_GAP: begin
                // Controller sees q_req low for a cycle before any new request
                beat_d  = '0;
                busy_d  = 1'b0;
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                beat_d  = '0;
                busy_d  = 1'b0;
                q_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            q_req_q   <= 1'b0;
            q_i_d_q   <= 1'b0;
            q_mem_q   <= 2'b00;
            q_write_q <= 1'b0;
            q_paddr_q <= '0;
            gnt_q     <= 3'b000;
            done_q    <= 3'b000;
`ifdef QSPI_ARB_AGE_EN
            age_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            q_req_q   <= q_req_d;
            q_i_d_q   <= q_i_d_d;
            q_mem_q   <= q_mem_d;
            q_write_q <= q_write_d;
            q_paddr_q <= q_paddr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
`ifdef QSPI_ARB_AGE_EN
            age_q     <= age_d;
`endif
        end
    end

    assign i_gnt   = gnt_q[0];
    assign d_gnt   = gnt_q[1];
    assign w_gnt   = gnt_q[2];
    assign i_done  = done_q[0];
    assign d_done  = done_q[1];
    assign w_done  = done_q[2];
    assign q_req   = q_req_q;
    assign q_i_d   = q_i_d_q;
    assign q_mem   = q_mem_q;
    assign q_write = q_write_q;
    assign q_paddr = q_paddr_q;
    assign beat    = beat_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Self-checking bench for qspi_arbiter: transaction-level model of the
// requesters and controller, randomized addresses, strobe spacing, stray
// strobes, power-up delays and mid-transfer resets.
module tb_qspi_arbiter;

    localparam int LL = 4;
    localparam int PA = 24;
    localparam int LW = 2;
    localparam int AW = PA - LW;
    localparam int NB = 2 * LL;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, w_req;
    logic [1:0]    i_mem, d_mem, w_mem;
    logic [AW-1:0] i_addr, d_addr, w_addr;
    logic          i_gnt, d_gnt, w_gnt, i_done, d_done, w_done;
    logic          q_req, q_i_d, q_write;
    logic [1:0]    q_mem;
    logic [AW-1:0] q_paddr;
    logic          q_wstrobe_i, q_wstrobe_d, q_rstrobe_d;
    logic [2:0]    beat;
    logic          busy;

    qspi_arbiter #(.LINE_LENGTH(LL), .PA(PA)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_mem(i_mem), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
        .d_req(d_req), .d_mem(d_mem), .d_addr(d_addr), .d_gnt(d_gnt), .d_done(d_done),
        .w_req(w_req), .w_mem(w_mem), .w_addr(w_addr), .w_gnt(w_gnt), .w_done(w_done),
        .q_req(q_req), .q_i_d(q_i_d), .q_mem(q_mem), .q_write(q_write), .q_paddr(q_paddr),
        .q_wstrobe_i(q_wstrobe_i), .q_wstrobe_d(q_wstrobe_d), .q_rstrobe_d(q_rstrobe_d),
        .beat(beat), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester model: index 0 = I-fill, 1 = D-fill, 2 = writeback
    bit            pend   [3];
    logic [AW-1:0] addr_m [3];
    logic [1:0]    mem_m  [3];
    int            age_m = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        i_req = pend[0]; i_mem = mem_m[0]; i_addr = addr_m[0];
        d_req = pend[1]; d_mem = mem_m[1]; d_addr = addr_m[1];
        w_req = pend[2]; w_mem = mem_m[2]; w_addr = addr_m[2];
    endtask

    task automatic raise(input int idx, input logic [AW-1:0] a);
        pend[idx]   = 1'b1;
        addr_m[idx] = a;
        mem_m[idx]  = 2'($urandom_range(0, 3));
    endtask

    task automatic set_strb(input logic [2:0] s);
        q_wstrobe_i = s[2];
        q_wstrobe_d = s[1];
        q_rstrobe_d = s[0];
    endtask

    // Expected winner from the pending set: writes beat reads, D beats I,
    // except that an I-fill aged through three data grants goes first
    function automatic int pick();
`ifdef QSPI_ARB_AGE_EN
        if (pend[0] && age_m >= 3) return 0;
`endif
        if (pend[2]) return 2;
        if (pend[1]) return 1;
        if (pend[0]) return 0;
        return -1;
    endfunction

    function automatic logic [2:0] stray(input logic [2:0] right);
        logic [2:0] r;
        r = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0) r = 3'b000;
        return r & ~right;
    endfunction

    // One arbitration + transfer. Called at a falling edge with the DUT idle.
    // abort_at >= 0 resets the DUT instead of issuing that strobe.
    task automatic round(input int pre_delay, input int abort_at, input bit force_drop, output int won);
        int         w;
        logic [2:0] oh;
        logic [2:0] right;
        w   = pick();
        won = w;
        if (w < 0) return;
        oh    = 3'b000;
        oh[w] = 1'b1;
        right = (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : 3'b001;
        drive_reqs();
        set_strb(3'b000);
        @(negedge clk);
        chk_eq("gnt", 32'({w_gnt, d_gnt, i_gnt}), 32'(oh));
        chk_eq("q_req_rise", 32'(q_req), 32'd1);
        chk_eq("busy_rise", 32'(busy), 32'd1);
        chk_eq("q_i_d", 32'(q_i_d), 32'(w == 0));
        chk_eq("q_write", 32'(q_write), 32'(w == 2));
        chk_eq("q_mem", 32'(q_mem), 32'(mem_m[w]));
        chk_eq("q_paddr", 32'(q_paddr), 32'(addr_m[w]));
        if (w == 0) age_m = 0;
        else if (pend[0]) age_m = (age_m < 3) ? age_m + 1 : 3;
        else age_m = 0;
        // Owner may let go of its request and change its inputs mid-transfer
        if (force_drop || $urandom_range(0, 1) == 1) begin
            case (w)
                0: begin i_req = 1'b0; i_addr = AW'($urandom); i_mem = ~mem_m[0]; end
                1: begin d_req = 1'b0; d_addr = AW'($urandom); d_mem = ~mem_m[1]; end
                default: begin w_req = 1'b0; w_addr = AW'($urandom); w_mem = ~mem_m[2]; end
            endcase
        end
        for (int c = 0; c < pre_delay; c++) begin
            set_strb(stray(right) | ((force_drop && w == 1) ? 3'b100 : 3'b000));
            @(negedge clk);
            chk_eq("powerup_q_req", 32'(q_req), 32'd1);
            chk_eq("powerup_done", 32'({w_done, d_done, i_done}), 32'd0);
        end
        for (int k = 0; k < NB; k++) begin
            int g = $urandom_range(0, 2);
            for (int c = 0; c < g; c++) begin
                set_strb(stray(right));
                @(negedge clk);
                chk_eq("hold_q_req", 32'(q_req), 32'd1);
                chk_eq("early_done", 32'({w_done, d_done, i_done}), 32'd0);
            end
            if (k == abort_at) begin
                set_strb(3'b000);
                reset = 1'b1;
                pend[0] = 1'b0; pend[1] = 1'b0; pend[2] = 1'b0;
                drive_reqs();
                age_m = 0;
                @(negedge clk);
                reset = 1'b0;
                chk_eq("rst_q_req", 32'(q_req), 32'd0);
                chk_eq("rst_busy", 32'(busy), 32'd0);
                chk_eq("rst_beat", 32'(beat), 32'd0);
                chk_eq("rst_done", 32'({w_done, d_done, i_done}), 32'd0);
                @(negedge clk);
                chk_eq("rst_no_done", 32'({w_done, d_done, i_done}), 32'd0);
                return;
            end
            set_strb(right | stray(right));
            #1;
            chk_eq("beat", 32'(beat), 32'(k));
            @(negedge clk);
            if (k < NB - 1) begin
                chk_eq("mid_q_req", 32'(q_req), 32'd1);
                chk_eq("mid_done", 32'({w_done, d_done, i_done}), 32'd0);
            end
        end
        set_strb(3'b000);
        chk_eq("done", 32'({w_done, d_done, i_done}), 32'(oh));
        chk_eq("gap_q_req", 32'(q_req), 32'd0);
        chk_eq("frozen_paddr", 32'(q_paddr), 32'(addr_m[w]));
        pend[w] = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk_eq("idle_q_req", 32'(q_req), 32'd0);
        chk_eq("idle_busy", 32'(busy), 32'd0);
        chk_eq("idle_done", 32'({w_done, d_done, i_done}), 32'd0);
        chk_eq("idle_beat", 32'(beat), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int won;
        int i_grant_at;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; addr_m[i] = '0; mem_m[i] = 2'b00;
        end
        drive_reqs();
        set_strb(3'b000);
        repeat (3) @(negedge clk);
        chk_eq("reset_q_req", 32'(q_req), 32'd0);
        chk_eq("reset_busy", 32'(busy), 32'd0);
        chk_eq("reset_beat", 32'(beat), 32'd0);
        chk_eq("reset_gnt", 32'({w_gnt, d_gnt, i_gnt}), 32'd0);
        chk_eq("reset_done", 32'({w_done, d_done, i_done}), 32'd0);
        chk_eq("reset_ctl", 32'({q_i_d, q_write, q_mem}), 32'd0);
        chk_eq("reset_paddr", 32'(q_paddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // I-fill alone
        raise(0, AW'(22'h12345));
        round(0, -1, 1'b0, won);
        // Writeback and D-fill in the same cycle
        raise(2, AW'($urandom)); raise(1, AW'($urandom));
        round(0, -1, 1'b0, won);
        round(0, -1, 1'b0, won);
        // Reset after three strobes of a read, then a fresh I-fill
        raise(0, AW'($urandom));
        round(0, 3, 1'b0, won);
        raise(0, AW'($urandom));
        round(0, -1, 1'b0, won);
        // D-fill with owner dropping req, stray I strobes, long power-up
        raise(1, AW'($urandom));
        round(20, -1, 1'b1, won);

        // Persistent data requests with a waiting I-fill
        i_grant_at = 0;
        raise(0, AW'($urandom));
        for (int n = 1; n <= 6; n++) begin
            if (!pend[1]) raise(1, AW'($urandom));
            if (!pend[2]) raise(2, AW'($urandom));
            round(0, -1, 1'b0, won);
            if (won == 0 && i_grant_at == 0) i_grant_at = n;
        end
`ifdef QSPI_ARB_AGE_EN
        chk_eq("age_i_grant_index", 32'(i_grant_at), 32'd4);
`else
        chk_eq("no_i_grant_fixed_prio", 32'(i_grant_at), 32'd0);
`endif

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            int pd;
            int ab;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) raise(i, AW'($urandom));
            end
            if (!pend[0] && !pend[1] && !pend[2]) raise($urandom_range(0, 2), AW'($urandom));
            pd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, NB - 1) : -1;
            round(pd, ab, 1'b0, won);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
